parallel2serial: RTL and testbench

Parallel-to-serial transmitter. It accepts WIDTH-bit words over a valid/ready handshake and shifts each word out one bit per clock on a single serial line, with a qualifying valid strobe and a last-bit marker. It is the transmit-side counterpart of the `serial2parallel` receiver. With default parameters, `dout_serial`/`dout_valid` connect directly to that block's `din_serial`/`din_valid` for loopback. A one-word holding register lets back-to-back words stream with no idle cycle between frames.

---
 rtl/parallel2serial.sv | 112 +++++++++++
 tb/tb_parallel2serial.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/parallel2serial.sv
// parallel2serial: valid/ready word input, one bit per clock on a serial line
// with a qualifying valid strobe and a last-bit marker. A one-word holding
// register lets consecutive words stream out with no idle cycle between them.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | nothing on the line, dout_valid = 0
// ST_SHIFT | presenting bit cnt of the current word, dout_valid = 1

module parallel2serial #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_parallel,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout_serial,
    output logic             dout_valid,
    output logic             dout_last
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [WIDTH-1:0] hold_reg;
    logic             hold_valid;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [CNT_W-1:0] cnt;
    logic [0:0]       state;
    logic             accept;
    logic             load;
    logic             first_bit;
    logic             next_bit;

    // Ready depends only on the holding flop, never on din_valid.
    assign din_ready = ~hold_valid;
    assign accept    = din_valid & din_ready;
    assign load      = hold_valid & ((state == ST_IDLE) | (cnt == CNT_LAST));

    // Next shifter contents and the bit it will present, in transmit order.
    always_comb begin
        shift_next = '0;
        first_bit  = 1'b0;
        next_bit   = 1'b0;
        if (MSB_FIRST) begin
            shift_next = {shift_reg[WIDTH-2:0], 1'b0};
            first_bit  = hold_reg[WIDTH-1];
            next_bit   = shift_next[WIDTH-1];
        end else begin
            shift_next = {1'b0, shift_reg[WIDTH-1:1]};
            first_bit  = hold_reg[0];
            next_bit   = shift_next[0];
        end
    end

    // Holding register: filled on handshake, emptied when the shifter loads.
    // Accept needs hold_valid = 0 and load needs hold_valid = 1, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg   <= '0;
            hold_valid <= 1'b0;
        end else if (accept) begin
            hold_reg   <= din_parallel;
            hold_valid <= 1'b1;
        end else if (load) begin
            hold_valid <= 1'b0;
        end
    end

    // Shifter FSM with registered serial outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            shift_reg   <= '0;
            dout_serial <= 1'b0;
            dout_valid  <= 1'b0;
            dout_last   <= 1'b0;
        end else if (load) begin
            state       <= ST_SHIFT;
            cnt         <= '0;
            shift_reg   <= hold_reg;
            dout_serial <= first_bit;
            dout_valid  <= 1'b1;
            dout_last   <= 1'b0;
        end else if (state == ST_SHIFT) begin
            if (cnt != CNT_LAST) begin
                cnt         <= cnt + CNT_W'(1);
                shift_reg   <= shift_next;
                dout_serial <= next_bit;
                dout_valid  <= 1'b1;
                dout_last   <= (cnt == CNT_PENULT);
            end else begin
                // Final bit done and nothing held: drop back to a quiet line.
                state       <= ST_IDLE;
                cnt         <= '0;
                shift_reg   <= '0;
                dout_serial <= 1'b0;
                dout_valid  <= 1'b0;
                dout_last   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_parallel2serial.sv
// Testbench for parallel2serial. Two instances (MSB-first and LSB-first) share
// one input stream; a bit-queue reference model predicts every output cycle,
// and a receiver-style monitor reassembles words and compares them in order.

module tb_parallel2serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din_parallel = '0;
    logic         din_valid = 1'b0;

    logic din_ready_m, dout_serial_m, dout_valid_m, dout_last_m;
    logic din_ready_l, dout_serial_l, dout_valid_l, dout_last_l;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the pending hold word plus the exact bits still to appear.
    logic [W-1:0] m_hold = '0;
    bit           m_hold_v = 1'b0;
    bit           q_m[$];
    bit           q_l[$];
    logic [W-1:0] exp_words[$];

    // Receiver-side reassembly.
    logic [W-1:0] acc_m = '0;
    logic [W-1:0] acc_l = '0;
    int           nb_m = 0;
    int           nb_l = 0;

    parallel2serial #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk          (clk),
        .rst_n        (rst_n),
        .din_parallel (din_parallel),
        .din_valid    (din_valid),
        .din_ready    (din_ready_m),
        .dout_serial  (dout_serial_m),
        .dout_valid   (dout_valid_m),
        .dout_last    (dout_last_m)
    );

    parallel2serial #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk          (clk),
        .rst_n        (rst_n),
        .din_parallel (din_parallel),
        .din_valid    (din_valid),
        .din_ready    (din_ready_l),
        .dout_serial  (dout_serial_l),
        .dout_valid   (dout_valid_l),
        .dout_last    (dout_last_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_hold_v = 1'b0;
        q_m.delete();
        q_l.delete();
        exp_words.delete();
        acc_m = '0;
        acc_l = '0;
        nb_m  = 0;
        nb_l  = 0;
    endtask

    // One rising edge of the model: the bit on the line is consumed, an empty
    // line pulls in the held word, and a free holding slot takes the input.
    task automatic model_edge(input bit v, input logic [W-1:0] d);
        bit acc;
        bit ld;
        acc = v && !m_hold_v;
        if (q_m.size() > 0) begin
            void'(q_m.pop_front());
            void'(q_l.pop_front());
        end
        ld = m_hold_v && (q_m.size() == 0);
        if (ld) begin
            for (int i = W - 1; i >= 0; i--) q_m.push_back(m_hold[i]);
            for (int i = 0; i < W; i++) q_l.push_back(m_hold[i]);
            m_hold_v = 1'b0;
        end
        if (acc) begin
            m_hold   = d;
            m_hold_v = 1'b1;
            exp_words.push_back(d);
        end
    endtask

    task automatic check_outputs();
        bit ev;
        ev = (q_m.size() > 0);
        chk("ready_msb",  din_ready_m,  !m_hold_v);
        chk("ready_lsb",  din_ready_l,  !m_hold_v);
        chk("valid_msb",  dout_valid_m, ev);
        chk("valid_lsb",  dout_valid_l, ev);
        chk("serial_msb", dout_serial_m, ev ? q_m[0] : 1'b0);
        chk("serial_lsb", dout_serial_l, ev ? q_l[0] : 1'b0);
        chk("last_msb",   dout_last_m,  q_m.size() == 1);
        chk("last_lsb",   dout_last_l,  q_l.size() == 1);
        if (dout_valid_l) begin
            acc_l = {dout_serial_l, acc_l[W-1:1]};
            nb_l++;
        end
        if (dout_valid_m) begin
            acc_m = {acc_m[W-2:0], dout_serial_m};
            nb_m++;
        end
        if (dout_last_m && dout_valid_m) begin
            chk("word_avail", exp_words.size() > 0, 1);
            if (exp_words.size() > 0) begin
                chk("word_bits_msb", nb_m, W);
                chk("word_bits_lsb", nb_l, W);
                chk("word_msb", acc_m, exp_words[0]);
                chk("word_lsb", acc_l, exp_words[0]);
                void'(exp_words.pop_front());
            end
            nb_m = 0;
            nb_l = 0;
        end
    endtask

    // One clock: drive inputs away from the edge, update model, sample on the falling edge.
    task automatic cycle(input bit v, input logic [W-1:0] d);
        din_valid    = v;
        din_parallel = d;
        @(posedge clk);
        model_edge(v, d);
        @(negedge clk);
        check_outputs();
    endtask

    // Offer a word, scrambling din_parallel while the block is not ready.
    task automatic send(input logic [W-1:0] d);
        int tries;
        tries = 0;
        while (m_hold_v && tries < 20) begin
            cycle(1'b1, W'($urandom));
            tries++;
        end
        if (m_hold_v) chk("send_timeout", 1, 0);
        cycle(1'b1, d);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_hold_v || q_m.size() > 0) && n < 40) begin
            cycle(1'b0, W'($urandom));
            n++;
        end
        if (m_hold_v || q_m.size() > 0) chk("drain_timeout", 1, 0);
        cycle(1'b0, '0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_ready"},  {din_ready_m, din_ready_l}, 2'b11);
        chk({tag, "_valid"},  {dout_valid_m, dout_valid_l}, 2'b00);
        chk({tag, "_serial"}, {dout_serial_m, dout_serial_l}, 2'b00);
        chk({tag, "_last"},   {dout_last_m, dout_last_l}, 2'b00);
    endtask

    initial begin
        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        model_clear();
        cycle(1'b0, '0);

        // Single word 0xA5: first bit 2 edges after accept, then idle again
        send(8'hA5);
        chk("a5_hold_ready", din_ready_m, 1'b0);
        drain();
        check_quiet("a5_idle");

        // LSB-first single bit word
        send(8'h01);
        drain();

        // Back-to-back with din_valid held high
        send(8'h3C);
        send(8'hF0);
        drain();

        // Backpressure: scrambled data while not ready, several words queued
        for (int k = 0; k < 6; k++) send(W'($urandom));
        drain();

        // Reset mid-word: 0xFF on the line, 0x55 held
        send(8'hFF);
        send(8'h55);
        while (q_m.size() > W - 4 && q_m.size() > 0) cycle(1'b0, '0);
        chk("midword_bit4_valid", dout_valid_m, 1'b1);
        chk("midword_hold", din_ready_m, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("async_reset");
        model_clear();
        @(posedge clk);
        @(negedge clk);
        check_quiet("in_reset");
        rst_n = 1'b1;
        repeat (12) cycle(1'b0, W'($urandom));
        check_quiet("after_reset");

        // Boundary words with idle gaps
        send(8'h00); drain();
        send(8'hFF); drain();
        send(8'h81); repeat (3) cycle(1'b0, '0);
        send(8'h7E); drain();

        // Randomized traffic with stalls
        for (int k = 0; k < 400; k++) cycle(($urandom_range(0, 3) != 0), W'($urandom));
        drain();
        chk("words_left", exp_words.size(), 0);
        check_quiet("final");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
